// File: rtl/argon_mem_pkg.sv
// argon_mem_pkg: shared byte-lane Memory mask encodings, funct3 op codes and LSU response causes.
package argon_mem_pkg;

    localparam logic [1:0] WRMASK_N = 2'd0;
    localparam logic [1:0] WRMASK_B = 2'd1;
    localparam logic [1:0] WRMASK_H = 2'd2;
    localparam logic [1:0] WRMASK_W = 2'd3;

    localparam logic [2:0] RDMASK_W  = 3'd0;
    localparam logic [2:0] RDMASK_HZ = 3'd1;
    localparam logic [2:0] RDMASK_BZ = 3'd2;
    localparam logic [2:0] RDMASK_HE = 3'd3;
    localparam logic [2:0] RDMASK_BE = 3'd4;
    localparam logic [2:0] RDMASK_XX = 3'd5;

    typedef enum logic [2:0] {
        LSU_OP_B  = 3'b000,
        LSU_OP_H  = 3'b001,
        LSU_OP_W  = 3'b010,
        LSU_OP_BU = 3'b100,
        LSU_OP_HU = 3'b101
    } lsu_op_e;

    typedef enum logic [1:0] {
        CAUSE_OK         = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_ILLEGAL    = 2'd2,
        CAUSE_MEM_ERR    = 2'd3
    } lsu_cause_e;

endpackage

// File: rtl/lsu_mask_decode.sv
// lsu_mask_decode: maps {we, funct3, addr[1:0]} to Memory lane masks plus illegal/misaligned flags.
module lsu_mask_decode
    import argon_mem_pkg::*;
(
    input  logic       we,
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic [1:0] wr_mask,
    output logic [2:0] rd_mask,
    output logic       illegal,
    output logic       misaligned,
    output logic [1:0] aligned_lo
);

    always_comb begin
        wr_mask = WRMASK_N;
        rd_mask = RDMASK_XX;
        illegal = 1'b0;
        case (op)
            LSU_OP_B: begin
                wr_mask = we ? WRMASK_B : WRMASK_N;
                rd_mask = we ? RDMASK_XX : RDMASK_BE;
            end
            LSU_OP_H: begin
                wr_mask = we ? WRMASK_H : WRMASK_N;
                rd_mask = we ? RDMASK_XX : RDMASK_HE;
            end
            LSU_OP_W: begin
                wr_mask = we ? WRMASK_W : WRMASK_N;
                rd_mask = we ? RDMASK_XX : RDMASK_W;
            end
            LSU_OP_BU: begin
                illegal = we;
                rd_mask = we ? RDMASK_XX : RDMASK_BZ;
            end
            LSU_OP_HU: begin
                illegal = we;
                rd_mask = we ? RDMASK_XX : RDMASK_HZ;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign misaligned = (op[1:0] == 2'b01 && addr_lo[0]) || (op == LSU_OP_W && addr_lo != 2'b00);
    assign aligned_lo = (op[1:0] == 2'b01) ? {addr_lo[1], 1'b0} :
                        (op == LSU_OP_W)   ? 2'b00 : addr_lo;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one load/store request into byte-lane Memory controls and returns one response.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN; otherwise low address bits are cleared.
module load_store_unit
    import argon_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_data,
    output logic [1:0]        o_resp_cause,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_wr_data,
    output logic [1:0]        o_mem_wr_mask,
    output logic [2:0]        o_mem_rd_mask,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    input  logic              i_mem_err_misal,
    input  logic              i_mem_err_rdmsk
);

    typedef logic [1:0] lsu_state_e;
    localparam lsu_state_e S_IDLE    = 2'd0;
    localparam lsu_state_e S_ISSUE   = 2'd1;
    localparam lsu_state_e S_CAPTURE = 2'd2;
    localparam lsu_state_e S_RESP    = 2'd3;

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS * 4);

    lsu_state_e        state;
    logic              we_q;
    logic [1:0]        wr_mask_q;
    logic [2:0]        rd_mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0] dec_wr_mask;
    logic [2:0] dec_rd_mask;
    logic       dec_illegal;
    logic       dec_misaligned;
    logic [1:0] dec_lo;
    logic       trap;
    logic       out_of_range;
    logic       reject;
    logic       issue;

    lsu_mask_decode u_decode (
        .we         (i_req_we),
        .op         (i_req_op),
        .addr_lo    (i_req_addr[1:0]),
        .wr_mask    (dec_wr_mask),
        .rd_mask    (dec_rd_mask),
        .illegal    (dec_illegal),
        .misaligned (dec_misaligned),
        .aligned_lo (dec_lo)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = dec_misaligned;
`else
    assign trap = 1'b0;
`endif

    assign out_of_range = {1'b0, i_req_addr} >= ADDR_LIMIT;
    assign reject       = dec_illegal | out_of_range | trap;
    assign issue        = state == S_ISSUE;
    assign o_req_ready  = state == S_IDLE;
    assign o_resp_valid = state == S_RESP;

    // Memory sees an access only during ISSUE, so each store writes exactly once.
    assign o_mem_address = issue ? addr_q : '0;
    assign o_mem_wr_data = issue ? wdata_q : '0;
    assign o_mem_wr_mask = issue ? wr_mask_q : WRMASK_N;
    assign o_mem_rd_mask = issue ? rd_mask_q : RDMASK_XX;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_IDLE;
            o_resp_data  <= '0;
            o_resp_cause <= CAUSE_OK;
            we_q         <= 1'b0;
            wr_mask_q    <= WRMASK_N;
            rd_mask_q    <= RDMASK_XX;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_req_valid) begin
                    we_q         <= i_req_we;
                    wr_mask_q    <= dec_wr_mask;
                    rd_mask_q    <= dec_rd_mask;
                    addr_q       <= {i_req_addr[ADDR_W-1:2], dec_lo};
                    wdata_q      <= i_req_wdata;
                    o_resp_data  <= '0;
                    o_resp_cause <= (dec_illegal | out_of_range) ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                    state        <= reject ? S_RESP : S_ISSUE;
                end
                S_ISSUE: state <= S_CAPTURE;
                S_CAPTURE: begin
                    o_resp_data  <= we_q ? '0 : i_mem_rd_data;
                    o_resp_cause <= (i_mem_err_misal | i_mem_err_rdmsk) ? CAUSE_MEM_ERR : CAUSE_OK;
                    state        <= S_RESP;
                end
                default: if (i_resp_ready) state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, hand-written corner sequences and random requests
// checked against a byte-array reference model; includes a behavioural byte-lane Memory.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [1:0]  resp_cause;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic [1:0]  mem_wr_mask;
    logic [2:0]  mem_rd_mask;
    logic [31:0] mem_rd_data = 32'd0;
    logic        mem_err_misal = 1'b0;
    logic        mem_err_rdmsk = 1'b0;
    logic [1:0]  err_inject = 2'b00;

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    logic [1:0] last_wm = 2'd0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_op       (req_op),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_data    (resp_data),
        .o_resp_cause   (resp_cause),
        .o_mem_address  (mem_address),
        .o_mem_wr_data  (mem_wr_data),
        .o_mem_wr_mask  (mem_wr_mask),
        .o_mem_rd_mask  (mem_rd_mask),
        .i_mem_rd_data  (mem_rd_data),
        .i_mem_err_misal(mem_err_misal),
        .i_mem_err_rdmsk(mem_err_rdmsk)
    );

    // Behavioural Memory: lane writes and a registered, extended read.
    logic [31:0] mem [0:1023];
    logic [31:0] mword;
    int          widx;
    always @(posedge clk) begin
        widx  = int'(mem_address[11:2]);
        mword = mem[widx];
        case (mem_wr_mask)
            2'd1: mem[widx][8*mem_address[1:0] +: 8] <= mem_wr_data[7:0];
            2'd2: mem[widx][16*mem_address[1] +: 16] <= mem_wr_data[15:0];
            2'd3: mem[widx] <= mem_wr_data;
            default: ;
        endcase
        case (mem_rd_mask)
            3'd0: mem_rd_data <= mword;
            3'd1: mem_rd_data <= {16'd0, mword[16*mem_address[1] +: 16]};
            3'd2: mem_rd_data <= {24'd0, mword[8*mem_address[1:0] +: 8]};
            3'd3: mem_rd_data <= {{16{mword[16*mem_address[1]+15]}}, mword[16*mem_address[1] +: 16]};
            3'd4: mem_rd_data <= {{24{mword[8*mem_address[1:0]+7]}}, mword[8*mem_address[1:0] +: 8]};
            default: mem_rd_data <= 32'd0;
        endcase
        mem_err_misal <= (mem_wr_mask != 2'd0 || mem_rd_mask != 3'd5) && err_inject[0];
        mem_err_rdmsk <= (mem_wr_mask != 2'd0 || mem_rd_mask != 3'd5) && err_inject[1];
        if (mem_wr_mask != 2'd0) begin
            wr_cnt  <= wr_cnt + 1;
            last_wm <= mem_wr_mask;
        end
    end

    // Reference model: flat byte array, request-level semantics.
    logic [7:0] ref_mem [0:4095];

    function automatic void model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [1:0] err,
                                  output logic [31:0] d, output logic [1:0] c, output int lat, output int wr);
        int size;
        int a;
        logic [31:0] v;
        bit legal;
        legal = (op == 3'd0 || op == 3'd1 || op == 3'd2 || ((op == 3'd4 || op == 3'd5) && !we));
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        d = 32'd0; c = 2'd2; lat = 1; wr = 0;
        if (!legal || addr >= 32'd4096) return;
        if (TRAP && (addr % size) != 0) begin
            c = 2'd1;
            return;
        end
        a   = int'(addr) - int'(addr % size);
        lat = 3;
        c   = (err != 2'b00) ? 2'd3 : 2'd0;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
            wr = 1;
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
            if (!op[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8*size));
            d = v;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic early_ready, output logic [31:0] d, output logic [1:0] c, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        resp_ready = early_ready;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = resp_data;
        c = resp_cause;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic [1:0]  exp_c;
        int          exp_lat;
        logic [1:0]  exp_wm;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] d, md;
        logic [1:0]  c, mc;
        int lat, mlat, mwr, w0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;

        vecs[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        2'd0, 3, 2'd3};
        vecs[1]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 2'd0, 3, 2'd0};
        vecs[2]  = '{1'b1, 3'd0, 32'h13,   32'h80,       32'h0,        2'd0, 3, 2'd1};
        vecs[3]  = '{1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFF80, 2'd0, 3, 2'd0};
        vecs[4]  = '{1'b0, 3'd4, 32'h13,   32'h0,        32'h00000080, 2'd0, 3, 2'd0};
        vecs[5]  = '{1'b1, 3'd1, 32'h22,   32'h8001,     32'h0,        2'd0, 3, 2'd2};
        vecs[6]  = '{1'b0, 3'd1, 32'h22,   32'h0,        32'hFFFF8001, 2'd0, 3, 2'd0};
        vecs[7]  = '{1'b0, 3'd5, 32'h20,   32'h0,        32'h00000000, 2'd0, 3, 2'd0};
        vecs[8]  = '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h0,        2'd2, 1, 2'd0};
        vecs[9]  = '{1'b1, 3'd4, 32'h0,    32'h5A,       32'h0,        2'd2, 1, 2'd0};
        vecs[10] = '{1'b0, 3'd3, 32'h4,    32'h0,        32'h0,        2'd2, 1, 2'd0};
        vecs[11] = '{1'b0, 3'd2, 32'h11,   32'h0,        TRAP ? 32'h0 : 32'h80ADBEEF, TRAP ? 2'd1 : 2'd0, TRAP ? 1 : 3, 2'd0};
        vecs[12] = '{1'b1, 3'd2, 32'hFFC,  32'h12345678, 32'h0,        2'd0, 3, 2'd3};
        vecs[13] = '{1'b0, 3'd2, 32'hFFC,  32'h0,        32'h12345678, 2'd0, 3, 2'd0};

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_resp_cause", 32'(resp_cause), 32'd0);
        chk("reset_wr_mask", 32'(mem_wr_mask), 32'd0);
        chk("reset_rd_mask", 32'(mem_rd_mask), 32'd5);
        chk("reset_address", mem_address, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            w0 = wr_cnt;
            last_wm = 2'd0;
            model(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, 2'b00, md, mc, mlat, mwr);
            txn(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, 1'b0, d, c, lat);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_d);
            chk($sformatf("vec%0d_cause", i), 32'(c), 32'(vecs[i].exp_c));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_writes", i), 32'(wr_cnt - w0), (vecs[i].exp_wm != 2'd0) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_wr_mask", i), 32'(last_wm), 32'(vecs[i].exp_wm));
        end

        // Response held off for 5 cycles must stay stable and block new requests.
        model(1'b0, 3'd2, 32'h10, 32'h0, 2'b00, md, mc, mlat, mwr);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'd2; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_data", resp_data, md);
            chk("stall_cause", 32'(resp_cause), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("stall_done_resp_valid", 32'(resp_valid), 32'd0);

        // Reset in CAPTURE drops the load.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'd2; req_addr = 32'h14;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cap_req_ready", 32'(req_ready), 32'd1);
        chk("rst_cap_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_cap_wr_mask", 32'(mem_wr_mask), 32'd0);
        chk("rst_cap_rd_mask", 32'(mem_rd_mask), 32'd5);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cap_no_resp", 32'(resp_valid), 32'd0);

        // Reset during ISSUE: the store still lands in Memory exactly once.
        w0 = wr_cnt;
        model(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 2'b00, md, mc, mlat, mwr);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'd2; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_issue_writes", 32'(wr_cnt - w0), 32'd1);
        chk("rst_issue_resp_valid", 32'(resp_valid), 32'd0);
        txn(1'b0, 3'd2, 32'h30, 32'h0, 1'b0, d, c, lat);
        chk("rst_issue_readback", d, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [2:0]  op;
            logic [31:0] addr, wd;
            logic        early;
            we    = 1'($urandom_range(0, 1));
            op    = ($urandom_range(0, 7) < 6) ? 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5) : $urandom_range(0, 2)) : 3'($urandom);
            addr  = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 64) : 32'($urandom_range(0, 127));
            wd    = $urandom;
            early = 1'($urandom_range(0, 1));
            err_inject = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            w0 = wr_cnt;
            model(we, op, addr, wd, err_inject, md, mc, mlat, mwr);
            txn(we, op, addr, wd, early, d, c, lat);
            err_inject = 2'b00;
            chk($sformatf("rnd%0d_data we=%0d op=%0d a=%h", i, we, op, addr), d, md);
            chk($sformatf("rnd%0d_cause", i), 32'(c), 32'(mc));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(mlat));
            chk($sformatf("rnd%0d_writes", i), 32'(wr_cnt - w0), 32'(mwr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
